// File: rtl/spike_rate_monitor.sv
// Spike rate monitor: counts rising edges of a LIF spike over a programmable window
// and tracks the latest inter-spike interval, reporting {rate, isi} on a valid/ready port.
module spike_rate_monitor #(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             window_tick,
  output logic             overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t state, state_nxt;

  logic             spike_d;
  logic [WIN_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_last;
  logic             isi_seen;

  logic             ev;
  logic             counting;
  logic             close;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] cnt_inc;
  logic [ISI_W-1:0] isi_cnt_inc;
  logic [ISI_W-1:0] isi_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = COUNT;
      COUNT:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An edge on the close cycle still belongs to the closing window's count and ISI.
  always_comb begin
    ev          = spike_in & ~spike_d;
    counting    = (state == COUNT) && enable;
    close       = counting && (rem == '0);
    accept      = out_valid && out_ready;
    load        = close && (!out_valid || out_ready);
    cnt_inc     = (ev && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    isi_cnt_inc = (isi_cnt != '1) ? isi_cnt + ISI_W'(1) : isi_cnt;
    isi_result  = ev ? (isi_seen ? isi_cnt : '0) : isi_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d  <= 1'b0;
      rem      <= '0;
      cnt      <= '0;
      isi_cnt  <= '0;
      isi_last <= '0;
      isi_seen <= 1'b0;
    end else begin
      spike_d <= spike_in;
      if (counting) begin
        cnt <= close ? '0 : cnt_inc;
        rem <= close ? window_len : rem - WIN_W'(1);
        if (ev) begin
          isi_last <= isi_seen ? isi_cnt : '0;
          isi_cnt  <= ISI_W'(1);
          isi_seen <= 1'b1;
        end else if (isi_seen) begin
          isi_cnt <= isi_cnt_inc;
        end
      end else begin
        rem      <= (state == IDLE && enable) ? window_len : '0;
        cnt      <= '0;
        isi_cnt  <= '0;
        isi_last <= '0;
        isi_seen <= 1'b0;
      end
    end
  end

  // One-deep result slot; a full, unaccepted slot keeps its data and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out    <= '0;
      isi_out     <= '0;
      out_valid   <= 1'b0;
      window_tick <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      window_tick <= close;
      if (load) begin
        rate_out  <= cnt_inc;
        isi_out   <= isi_result;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (state == IDLE && enable) overrun <= 1'b0;
      else if (close && !load)     overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor with hand-computed expectations
// checked by immediate assertions.
module tb_spike_rate_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       spike_in;
  logic [7:0] window_len;
  logic [7:0] rate_out;
  logic [7:0] isi_out;
  logic       out_valid;
  logic       out_ready;
  logic       window_tick;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  spike_rate_monitor #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .rate_out    (rate_out),
    .isi_out     (isi_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .window_tick (window_tick),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_result(input string tag, input int valid, input int rate, input int isi);
    check_output({tag, "_valid"}, int'(out_valid), valid);
    check_output({tag, "_rate"}, int'(rate_out), rate);
    check_output({tag, "_isi"}, int'(isi_out), isi);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    spike_in   = 1'b0;
    window_len = 8'd0;
    out_ready  = 1'b0;
    tick();
    tick();
    check_result("reset", 0, 0, 0);
    check_output("reset_tick", int'(window_tick), 0);
    check_output("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // 1: spikes at window cycles 0,3,6,9 of a 10-cycle window
    $display("[TB] test 1: periodic spikes");
    window_len = 8'd9;
    out_ready  = 1'b1;
    enable     = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c % 3 == 0);
      tick();
    end
    check_result("t1", 1, 4, 3);
    check_output("t1_tick", int'(window_tick), 1);
    spike_in = 1'b0;
    tick();
    check_output("t1_tick_once", int'(window_tick), 0);
    check_result("t1_accept", 0, 4, 3);

    // 2: spike held high for 5 cycles counts as one edge
    $display("[TB] test 2: held spike");
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      spike_in = (c >= 2 && c <= 6);
      tick();
    end
    check_result("t2", 1, 1, 0);

    // 3: two edges 300 cycles apart across 256-cycle windows
    $display("[TB] test 3: ISI saturation");
    enable = 1'b0;
    tick();
    window_len = 8'd255;
    enable     = 1'b1;
    tick();
    for (int c = 0; c < 512; c++) begin
      spike_in = (c == 0 || c == 300);
      tick();
      if (c == 255) check_result("t3_win1", 1, 1, 0);
    end
    check_result("t3_win2", 1, 1, 255);
    check_output("t3_tick", int'(window_tick), 1);

    // 4: consumer stalled across two closes
    $display("[TB] test 4: overrun");
    spike_in = 1'b0;
    enable   = 1'b0;
    tick();
    check_output("t4_drain", int'(out_valid), 0);
    window_len = 8'd3;
    enable     = 1'b1;
    out_ready  = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      spike_in = (c == 0 || c == 2 || c == 4);
      tick();
      if (c == 3) check_result("t4_first", 1, 2, 2);
    end
    check_result("t4_held", 1, 2, 2);
    check_output("t4_overrun", int'(overrun), 1);
    check_output("t4_tick", int'(window_tick), 1);
    spike_in  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_result("t4_accept", 0, 2, 2);
    check_output("t4_sticky", int'(overrun), 1);

    // 5: close coincides with an accept
    $display("[TB] test 5: accept at close");
    enable    = 1'b0;
    out_ready = 1'b0;
    tick();
    check_output("t5_idle_overrun", int'(overrun), 1);
    enable = 1'b1;
    tick();
    check_output("t5_overrun_clr", int'(overrun), 0);
    for (int c = 0; c < 8; c++) begin
      spike_in  = (c == 1 || c == 4 || c == 6);
      out_ready = (c == 7);
      if (c == 7) window_len = 8'd9;
      tick();
      if (c == 3) check_result("t5_first", 1, 1, 0);
    end
    check_result("t5_second", 1, 2, 2);
    check_output("t5_overrun", int'(overrun), 0);
    check_output("t5_tick", int'(window_tick), 1);

    // 6: disable mid-window, then asynchronous reset mid-window
    $display("[TB] test 6: abort and reset");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      spike_in = (c == 1);
      tick();
    end
    enable   = 1'b0;
    spike_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output("t6_no_tick", int'(window_tick), 0);
    end
    check_result("t6_pending", 1, 2, 2);
    enable = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_result("t6_reset", 0, 0, 0);
    check_output("t6_reset_tick", int'(window_tick), 0);
    check_output("t6_reset_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
